branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic predictor for `beq` in the 5-stage RV32I pipeline.
- Predicts the branch in ID using a table of 2-bit saturating counters (BHT) indexed by PC.
- Resolves the branch in EX and produces `BEQ_WRONG_PRED` plus the corrected fetch PC. `BEQ_WRONG_PRED` is the same signal the hazard unit consumes for flush control.
- Keeps its own ID→EX shadow pipeline. That pipeline honours the hazard unit's `STALL` bubble and self-flushes on mispredict.

Parameters:
- XLEN, 32, datapath/PC width.
- IDX_W, 6, BHT index width; the table has 2**IDX_W entries, indexed by PC[IDX_W+1:2].
- INIT_STATE, 2'b01, reset value of every BHT entry (weakly not-taken).

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  reset, asynchronous, active-low.
- STALL  input  1  load-use stall from the hazard unit; holds IF/ID and inserts a bubble into ID/EX.
- OP_CODE_ID  input  7  opcode of the instruction in ID.
- PC_ID  input  XLEN  PC of the instruction in ID.
- IMM_ID  input  XLEN  sign-extended B-type offset (byte units) of the instruction in ID.
- PRED_TAKEN  output  1  combinational ID prediction; 1 only if OP_CODE_ID==7'b1100011 and BHT[idx(PC_ID)][1]==1.
- PRED_TARGET  output  XLEN  combinational, PC_ID+IMM_ID (wraps modulo 2**XLEN).
- BR_TAKEN_EX  input  1  actual `beq` outcome computed by the ALU in EX.
- BEQ_WRONG_PRED  output  1  mispredict of the branch currently in EX.
- CORRECT_PC  output  XLEN  fetch redirect PC for a mispredict.
- BR_COUNT  output  32  resolved branches; saturating.
- MISS_COUNT  output  32  mispredicts; saturating.

Behaviour:
- Reset (RST_N low, takes effect asynchronously):
  - every BHT entry = INIT_STATE;
  - vld_ex, taken_ex = 0; pc_ex, target_ex = 0;
  - BR_COUNT, MISS_COUNT = 0.
  - As a result, BEQ_WRONG_PRED=0 and CORRECT_PC=4 while in reset.
  - Assertion mid-operation drops any in-flight branch with no BHT update.
- Shadow registers, updated each rising edge, priority order:
  1. BEQ_WRONG_PRED=1 → vld_ex<=0 (the ID instruction is wrong-path).
  2. else STALL=1 → vld_ex<=0 (bubble).
  3. else vld_ex<=(OP_CODE_ID==beq_op), taken_ex<=PRED_TAKEN, pc_ex<=PC_ID, target_ex<=PRED_TARGET.
- Resolution (combinational from EX):
  - BEQ_WRONG_PRED = vld_ex & (BR_TAKEN_EX != taken_ex).
  - CORRECT_PC = BR_TAKEN_EX ? target_ex : pc_ex+4. The value is meaningful only when BEQ_WRONG_PRED=1.
  - Branch latency: predicted in ID, resolved one cycle later in EX.
- BHT update (on clock, when vld_ex=1), entry idx(pc_ex):
  - taken → saturating increment: 00→01→10→11→11.
  - not taken → saturating decrement: 11→10→01→00→00.
- Statistics (when vld_ex=1):
  - BR_COUNT += 1;
  - MISS_COUNT += BEQ_WRONG_PRED;
  - both hold at 32'hFFFF_FFFF.
- Same-cycle update and lookup of the same index: PRED_TAKEN uses the pre-update value; there is no bypass.
- STALL and BEQ_WRONG_PRED together: the flush wins; there is exactly one bubble and no double count.
- Non-`beq` opcodes in ID: PRED_TAKEN=0, and no shadow entry is created (vld_ex<=0).
- Aliasing: PCs differing only above bit IDX_W+1 share an entry. This is intended; there are no tags.

Decomposition:
- riscv_pkg holds:
  - opcode localparams (beq_op, arit_op, sw_op, lw_op);
  - typedef enum logic[1:0] bht_state_t {SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11};
  - function bht_next(bht_state_t, logic taken).
- One sub-module, bht_table:
  - 2**IDX_W × bht_state_t;
  - async-reset storage;
  - one combinational read port and one synchronous write port.

Test Plan:
- Reset with RST_N=0, then any PC_ID with beq opcode → PRED_TAKEN=0, BEQ_WRONG_PRED=0, BR_COUNT=0, MISS_COUNT=0.
- Branch at PC 0x40, IMM 0x20, taken on first pass → EX cycle BEQ_WRONG_PRED=1, CORRECT_PC=0x60. Next beq at 0x40 → PRED_TAKEN=1 (WT), correct, entry→ST. Then not taken → BEQ_WRONG_PRED=1, CORRECT_PC=0x44, entry→WT, still PRED_TAKEN=1. BR_COUNT=3, MISS_COUNT=2.
- beq in ID with STALL=1 for one cycle → no resolution that cycle, no BHT write. Branch resolves one cycle later; BR_COUNT increments by exactly 1.
- Mispredict in EX while another beq sits in ID → that ID branch never reaches EX (vld_ex=0 next cycle); BR_COUNT increments by 1 only.
- Train PC 0x40 to ST, then lookup PC 0x140 (IDX_W=6) → PRED_TAKEN=1 (alias). PC 0x44 → PRED_TAKEN=0.
- Drop RST_N mid-cycle while BEQ_WRONG_PRED=1 → BEQ_WRONG_PRED falls before the next clock edge; all BHT entries back to WNT.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the beq predictor: opcodes, 2-bit BHT
// counter encoding and the saturating counter transition function.
package riscv_pkg;

  localparam logic [6:0] beq_op  = 7'b1100011;
  localparam logic [6:0] arit_op = 7'b0110011;
  localparam logic [6:0] sw_op   = 7'b0100011;
  localparam logic [6:0] lw_op   = 7'b0000011;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic bht_state_t bht_next(input bht_state_t state, input logic taken);
    bht_state_t nxt;
    nxt = state;
    unique case (state)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
      default: nxt = state;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: 2**IDX_W two-bit saturating counters.
// Ports:
//   i_clk, i_rst_n       clock, async active-low reset (all entries -> INIT_STATE)
//   i_rd_idx / o_rd_state combinational lookup
//   i_wr_en, i_wr_idx,    synchronous counter update toward i_wr_taken
//   i_wr_taken
module bht_table
  import riscv_pkg::*;
#(
  parameter int unsigned IDX_W      = 6,
  parameter bht_state_t  INIT_STATE = WNT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output bht_state_t       o_rd_state,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  bht_state_t r_bht [DEPTH];

  // Read returns the stored value; an update in the same cycle lands only at the edge.
  assign o_rd_state = r_bht[i_rd_idx];

  // Counter storage with read-modify-write update of one entry per cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_bht[i] <= INIT_STATE;
      end
    end else if (i_wr_en) begin
      r_bht[i_wr_idx] <= bht_next(r_bht[i_wr_idx], i_wr_taken);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic beq predictor for the 5-stage RV32I pipeline. Predicts in ID from
// a PC-indexed BHT, resolves in EX against the ALU outcome, and keeps its own
// ID->EX shadow stage that honours STALL and self-flushes on mispredict.
// Ports:
//   CLK, RST_N                         clock, async active-low reset
//   STALL                              load-use bubble request from hazard unit
//   OP_CODE_ID, PC_ID, IMM_ID          instruction currently in ID
//   PRED_TAKEN, PRED_TARGET            combinational ID prediction
//   BR_TAKEN_EX                        actual beq outcome in EX
//   BEQ_WRONG_PRED, CORRECT_PC         combinational mispredict + redirect PC
//   BR_COUNT, MISS_COUNT               saturating statistics
module branch_predictor
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned IDX_W      = 6,
  parameter bht_state_t  INIT_STATE = WNT
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            STALL,
  input  logic [6:0]      OP_CODE_ID,
  input  logic [XLEN-1:0] PC_ID,
  input  logic [XLEN-1:0] IMM_ID,
  output logic            PRED_TAKEN,
  output logic [XLEN-1:0] PRED_TARGET,
  input  logic            BR_TAKEN_EX,
  output logic            BEQ_WRONG_PRED,
  output logic [XLEN-1:0] CORRECT_PC,
  output logic [31:0]     BR_COUNT,
  output logic [31:0]     MISS_COUNT
);

  localparam int unsigned CNT_W = 32;

  logic             w_is_beq_id;
  logic [IDX_W-1:0] w_idx_id;
  logic [IDX_W-1:0] w_idx_ex;
  bht_state_t       w_state_id;

  logic             r_vld_ex;
  logic             r_taken_ex;
  logic [XLEN-1:0]  r_pc_ex;
  logic [XLEN-1:0]  r_target_ex;
  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_miss_count;

  // Word-aligned PC bits select the counter; upper PC bits alias by design.
  assign w_idx_id    = PC_ID[IDX_W+1:2];
  assign w_idx_ex    = r_pc_ex[IDX_W+1:2];
  assign w_is_beq_id = (OP_CODE_ID == beq_op);

  bht_table #(
    .IDX_W      (IDX_W),
    .INIT_STATE (INIT_STATE)
  ) u_bht (
    .i_clk      (CLK),
    .i_rst_n    (RST_N),
    .i_rd_idx   (w_idx_id),
    .o_rd_state (w_state_id),
    .i_wr_en    (r_vld_ex),
    .i_wr_idx   (w_idx_ex),
    .i_wr_taken (BR_TAKEN_EX)
  );

  // ID prediction: counter MSB is the taken/not-taken decision.
  assign PRED_TAKEN  = w_is_beq_id & w_state_id[1];
  assign PRED_TARGET = PC_ID + IMM_ID;

  // EX resolution against the direction that was predicted in ID.
  assign BEQ_WRONG_PRED = r_vld_ex & (BR_TAKEN_EX != r_taken_ex);
  assign CORRECT_PC     = BR_TAKEN_EX ? r_target_ex : (r_pc_ex + XLEN'(4));

  // Shadow ID->EX stage; a mispredict flush outranks the stall bubble.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_vld_ex    <= 1'b0;
      r_taken_ex  <= 1'b0;
      r_pc_ex     <= '0;
      r_target_ex <= '0;
    end else if (BEQ_WRONG_PRED || STALL) begin
      r_vld_ex <= 1'b0;
    end else begin
      r_vld_ex    <= w_is_beq_id;
      r_taken_ex  <= PRED_TAKEN;
      r_pc_ex     <= PC_ID;
      r_target_ex <= PRED_TARGET;
    end
  end

  // Saturating resolved-branch and mispredict counters.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_br_count   <= '0;
      r_miss_count <= '0;
    end else if (r_vld_ex) begin
      if (r_br_count != '1) begin
        r_br_count <= r_br_count + CNT_W'(1);
      end
      if (BEQ_WRONG_PRED && (r_miss_count != '1)) begin
        r_miss_count <= r_miss_count + CNT_W'(1);
      end
    end
  end

  assign BR_COUNT   = r_br_count;
  assign MISS_COUNT = r_miss_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (IDX_W=6, INIT_STATE=WNT).
module tb_branch_predictor;

  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  logic        CLK;
  logic        RST_N;
  logic        STALL;
  logic [6:0]  OP_CODE_ID;
  logic [31:0] PC_ID;
  logic [31:0] IMM_ID;
  logic        PRED_TAKEN;
  logic [31:0] PRED_TARGET;
  logic        BR_TAKEN_EX;
  logic        BEQ_WRONG_PRED;
  logic [31:0] CORRECT_PC;
  logic [31:0] BR_COUNT;
  logic [31:0] MISS_COUNT;

  int n_checks;
  int n_errors;

  branch_predictor u_dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .STALL          (STALL),
    .OP_CODE_ID     (OP_CODE_ID),
    .PC_ID          (PC_ID),
    .IMM_ID         (IMM_ID),
    .PRED_TAKEN     (PRED_TAKEN),
    .PRED_TARGET    (PRED_TARGET),
    .BR_TAKEN_EX    (BR_TAKEN_EX),
    .BEQ_WRONG_PRED (BEQ_WRONG_PRED),
    .CORRECT_PC     (CORRECT_PC),
    .BR_COUNT       (BR_COUNT),
    .MISS_COUNT     (MISS_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a new ID instruction / EX outcome and let combinational paths settle.
  task automatic drive(input logic [6:0] op, input logic [31:0] pc, input logic [31:0] imm,
                       input logic stall, input logic taken_ex);
    OP_CODE_ID  = op;
    PC_ID       = pc;
    IMM_ID      = imm;
    STALL       = stall;
    BR_TAKEN_EX = taken_ex;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    RST_N = 1'b0;
    drive(OP_BEQ, 32'h40, 32'h20, 1'b0, 1'b0);

    // Reset state
    #2;
    chk("rst_pred",  {31'd0, PRED_TAKEN}, 32'd0);
    chk("rst_wrong", {31'd0, BEQ_WRONG_PRED}, 32'd0);
    chk("rst_cpc",   CORRECT_PC, 32'h4);
    chk("rst_br",    BR_COUNT, 32'd0);
    chk("rst_miss",  MISS_COUNT, 32'd0);
    tick();
    tick();
    RST_N = 1'b1;

    // beq 0x40 first pass: WNT predicts not taken, target 0x60
    drive(OP_BEQ, 32'h40, 32'h20, 1'b0, 1'b0);
    chk("p1_pred",   {31'd0, PRED_TAKEN}, 32'd0);
    chk("p1_target", PRED_TARGET, 32'h60);
    tick();
    drive(OP_ALU, 32'h44, 32'h0, 1'b0, 1'b1);
    chk("p1_wrong",  {31'd0, BEQ_WRONG_PRED}, 32'd1);
    chk("p1_cpc",    CORRECT_PC, 32'h60);
    tick();

    // Second pass: entry now WT, predicted taken and resolved taken -> ST
    drive(OP_BEQ, 32'h40, 32'h20, 1'b0, 1'b0);
    chk("p2_pred",   {31'd0, PRED_TAKEN}, 32'd1);
    chk("p2_br",     BR_COUNT, 32'd1);
    chk("p2_miss",   MISS_COUNT, 32'd1);
    tick();
    drive(OP_ALU, 32'h44, 32'h0, 1'b0, 1'b1);
    chk("p2_wrong",  {31'd0, BEQ_WRONG_PRED}, 32'd0);
    tick();

    // Third pass: ST predicts taken, resolved not taken -> redirect 0x44, entry WT
    drive(OP_BEQ, 32'h40, 32'h20, 1'b0, 1'b0);
    chk("p3_pred",   {31'd0, PRED_TAKEN}, 32'd1);
    tick();
    drive(OP_ALU, 32'h44, 32'h0, 1'b0, 1'b0);
    chk("p3_wrong",  {31'd0, BEQ_WRONG_PRED}, 32'd1);
    chk("p3_cpc",    CORRECT_PC, 32'h44);
    tick();
    drive(OP_BEQ, 32'h40, 32'h20, 1'b0, 1'b0);
    chk("p4_pred_wt", {31'd0, PRED_TAKEN}, 32'd1);
    chk("p3_br",     BR_COUNT, 32'd3);
    chk("p3_miss",   MISS_COUNT, 32'd2);
    tick();
    // Resolve taken: WT -> ST, BR=4
    drive(OP_ALU, 32'h44, 32'h0, 1'b0, 1'b1);
    chk("p4_wrong",  {31'd0, BEQ_WRONG_PRED}, 32'd0);
    tick();

    // Stall: beq 0x80 held one cycle in ID, resolves one cycle later
    drive(OP_BEQ, 32'h80, 32'h10, 1'b1, 1'b0);
    chk("st_pred",   {31'd0, PRED_TAKEN}, 32'd0);
    tick();
    drive(OP_BEQ, 32'h80, 32'h10, 1'b0, 1'b1);
    chk("st_bubble", {31'd0, BEQ_WRONG_PRED}, 32'd0);
    chk("st_br0",    BR_COUNT, 32'd4);
    tick();
    drive(OP_ALU, 32'h84, 32'h0, 1'b0, 1'b0);
    chk("st_wrong",  {31'd0, BEQ_WRONG_PRED}, 32'd0);
    tick();
    // Non-beq at a strongly-taken index never predicts taken
    drive(OP_ALU, 32'h40, 32'h20, 1'b0, 1'b0);
    chk("nb_pred",   {31'd0, PRED_TAKEN}, 32'd0);
    chk("st_br1",    BR_COUNT, 32'd5);
    tick();

    // Mispredict in EX while a beq sits in ID: ID beq is flushed
    drive(OP_BEQ, 32'h80, 32'h10, 1'b0, 1'b0);
    chk("fl_pred_snt", {31'd0, PRED_TAKEN}, 32'd0);
    tick();
    drive(OP_BEQ, 32'h40, 32'h20, 1'b0, 1'b1);
    chk("fl_pred_st", {31'd0, PRED_TAKEN}, 32'd1);
    chk("fl_wrong",  {31'd0, BEQ_WRONG_PRED}, 32'd1);
    chk("fl_cpc",    CORRECT_PC, 32'h90);
    tick();
    drive(OP_ALU, 32'h44, 32'h0, 1'b0, 1'b0);
    chk("fl_killed", {31'd0, BEQ_WRONG_PRED}, 32'd0);
    tick();
    drive(OP_ALU, 32'h48, 32'h0, 1'b0, 1'b0);
    chk("fl_br",     BR_COUNT, 32'd6);
    chk("fl_miss",   MISS_COUNT, 32'd3);

    // Stall and mispredict together: single bubble, single count
    drive(OP_BEQ, 32'h80, 32'h10, 1'b0, 1'b0);
    chk("sf_pred",   {31'd0, PRED_TAKEN}, 32'd0);
    tick();
    drive(OP_BEQ, 32'h40, 32'h20, 1'b1, 1'b1);
    chk("sf_wrong",  {31'd0, BEQ_WRONG_PRED}, 32'd1);
    tick();
    drive(OP_ALU, 32'h44, 32'h0, 1'b0, 1'b1);
    chk("sf_bubble", {31'd0, BEQ_WRONG_PRED}, 32'd0);
    tick();
    drive(OP_ALU, 32'h48, 32'h0, 1'b0, 1'b0);
    chk("sf_br",     BR_COUNT, 32'd7);
    chk("sf_miss",   MISS_COUNT, 32'd4);

    // Aliasing: 0x140 shares index with 0x40 (ST); 0x44 is untouched (WNT)
    drive(OP_BEQ, 32'h140, 32'h0, 1'b0, 1'b0);
    chk("alias_140", {31'd0, PRED_TAKEN}, 32'd1);
    drive(OP_BEQ, 32'h44, 32'h0, 1'b0, 1'b0);
    chk("alias_44",  {31'd0, PRED_TAKEN}, 32'd0);
    drive(OP_ALU, 32'h44, 32'h0, 1'b0, 1'b0);
    tick();

    // Reset mid-cycle while a mispredict is visible
    drive(OP_BEQ, 32'h40, 32'h20, 1'b0, 1'b0);
    tick();
    drive(OP_ALU, 32'h44, 32'h0, 1'b0, 1'b0);
    chk("mr_wrong1", {31'd0, BEQ_WRONG_PRED}, 32'd1);
    #1;
    RST_N = 1'b0;
    #1;
    chk("mr_wrong0", {31'd0, BEQ_WRONG_PRED}, 32'd0);
    chk("mr_cpc",    CORRECT_PC, 32'h4);
    chk("mr_br",     BR_COUNT, 32'd0);
    chk("mr_miss",   MISS_COUNT, 32'd0);
    tick();
    RST_N = 1'b1;

    // Entries back at WNT: 0x40 not taken; one taken update makes it WT
    drive(OP_BEQ, 32'h40, 32'h20, 1'b0, 1'b0);
    chk("mr_pred40", {31'd0, PRED_TAKEN}, 32'd0);
    drive(OP_BEQ, 32'h80, 32'h10, 1'b0, 1'b0);
    chk("mr_pred80", {31'd0, PRED_TAKEN}, 32'd0);
    drive(OP_BEQ, 32'h40, 32'h20, 1'b0, 1'b0);
    tick();
    drive(OP_ALU, 32'h44, 32'h0, 1'b0, 1'b1);
    chk("mr_wrong2", {31'd0, BEQ_WRONG_PRED}, 32'd1);
    tick();
    drive(OP_BEQ, 32'h40, 32'h20, 1'b0, 1'b0);
    chk("mr_pred_wt", {31'd0, PRED_TAKEN}, 32'd1);
    chk("mr_br1",    BR_COUNT, 32'd1);
    chk("mr_miss1",  MISS_COUNT, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
